// File: rtl/gpu_inst_decoder.sv
// gpu_inst_decoder
//   Pops a 1-4 word instruction (header + 0/2/3 vertex words) from a
//   first-word-fall-through command FIFO while the controller requests a
//   decode. Unpacks it into registered shape/alpha fields and holds them
//   until the consuming engine acknowledges.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   read_en            : controller decode request (level)
//   fifo_empty         : command FIFO empty
//   fifo_rdata         : FIFO head word (valid when fifo_empty = 0)
//   fifo_rd            : pop strobe, head advances on the same edge
//   inst_ack           : consumer has latched the fields
//   decode_fin         : one-cycle pulse, fields valid
//   decode_full        : fields held, not yet acknowledged
//   decode_err         : one-cycle pulse after an illegal opcode is popped
//   inst_type          : 0 = shape, 1 = alpha
//   num_vert           : 2 = line, 3 = triangle, 0 = alpha
//   fill, color, alpha : shape fill flag, RGB888 color, blend factor
//   v0..v2 x/y         : vertex coordinates
module gpu_inst_decoder #(
    parameter int unsigned CW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          read_en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_rd,
    input  logic          inst_ack,
    output logic          decode_fin,
    output logic          decode_full,
    output logic          decode_err,
    output logic          inst_type,
    output logic [1:0]    num_vert,
    output logic          fill,
    output logic [23:0]   color,
    output logic [7:0]    alpha,
    output logic [CW-1:0] v0_x,
    output logic [CW-1:0] v0_y,
    output logic [CW-1:0] v1_x,
    output logic [CW-1:0] v1_y,
    output logic [CW-1:0] v2_x,
    output logic [CW-1:0] v2_y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_OPER,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_LINE  = 4'd1;
    localparam logic [3:0] OP_TRI   = 4'd2;
    localparam logic [3:0] OP_ALPHA = 4'd3;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          err_q, err_d;

    logic          inst_type_q;
    logic [1:0]    num_vert_q;
    logic          fill_q;
    logic [23:0]   color_q;
    logic [7:0]    alpha_q;
    logic [CW-1:0] vx_q [3];
    logic [CW-1:0] vy_q [3];

    logic          pop;
    logic          hdr_pop;
    logic          vtx_pop;
    logic [3:0]    opcode;
    logic          op_legal;

    assign opcode   = fifo_rdata[31:28];
    assign op_legal = (opcode == OP_LINE) || (opcode == OP_TRI) || (opcode == OP_ALPHA);

    // Header bits 27:26 carry no information in any word format.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^fifo_rdata[27:26];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        hdr_pop = 1'b0;
        vtx_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read_en && !full_q) state_d = S_HDR;
            end
            S_HDR: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hdr_pop = 1'b1;
                    case (opcode)
                        OP_LINE, OP_TRI: begin
                            cnt_d   = 2'd0;
                            state_d = S_OPER;
                        end
                        OP_ALPHA: state_d = S_DONE;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_OPER: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    vtx_pop = 1'b1;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == num_vert_q - 2'd1) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        full_d = (state_q == S_DONE) || (full_q && !inst_ack);
        err_d  = hdr_pop && !op_legal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            inst_type_q <= 1'b0;
            num_vert_q  <= '0;
            fill_q      <= 1'b0;
            color_q     <= '0;
            alpha_q     <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            err_q   <= err_d;
            if (hdr_pop) begin
                if (opcode == OP_LINE || opcode == OP_TRI) begin
                    inst_type_q <= 1'b0;
                    num_vert_q  <= (opcode == OP_LINE) ? 2'd2 : 2'd3;
                    fill_q      <= fifo_rdata[24];
                    color_q     <= fifo_rdata[23:0];
                end else if (opcode == OP_ALPHA) begin
                    inst_type_q <= 1'b1;
                    num_vert_q  <= 2'd0;
                    fill_q      <= 1'b0;
                    alpha_q     <= fifo_rdata[7:0];
                end
            end
            for (int unsigned i = 0; i < 3; i++) begin
                if (vtx_pop && cnt_q == 2'(i)) begin
                    vx_q[i] <= fifo_rdata[16 +: CW];
                    vy_q[i] <= fifo_rdata[0 +: CW];
                end
            end
        end
    end

    // Pop is masked during reset so an aborted decode never advances the FIFO.
    assign fifo_rd     = pop && !rst;
    assign decode_fin  = (state_q == S_DONE);
    assign decode_full = full_q;
    assign decode_err  = err_q;
    assign inst_type   = inst_type_q;
    assign num_vert    = num_vert_q;
    assign fill        = fill_q;
    assign color       = color_q;
    assign alpha       = alpha_q;
    assign v0_x        = vx_q[0];
    assign v0_y        = vy_q[0];
    assign v1_x        = vx_q[1];
    assign v1_y        = vy_q[1];
    assign v2_x        = vx_q[2];
    assign v2_y        = vy_q[2];

endmodule

// File: tb/tb_gpu_inst_decoder.sv
module tb_gpu_inst_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_rdata = '0;
    logic        fifo_rd;
    logic        inst_ack = 1'b0;
    logic        decode_fin, decode_full, decode_err, inst_type, fill;
    logic [1:0]  num_vert;
    logic [23:0] color;
    logic [7:0]  alpha;
    logic [9:0]  v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;

    always #5 clk = ~clk;

    gpu_inst_decoder #(.CW(10), .DW(32)) dut (
        .clk(clk), .rst(rst), .read_en(read_en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd), .inst_ack(inst_ack),
        .decode_fin(decode_fin), .decode_full(decode_full), .decode_err(decode_err),
        .inst_type(inst_type), .num_vert(num_vert), .fill(fill), .color(color),
        .alpha(alpha), .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y),
        .v2_x(v2_x), .v2_y(v2_y)
    );

    typedef struct {
        logic [3:0][31:0] w;
        int               nw;
        int               sf, sl;     // forced-empty window: cycles [sf, sf+sl)
        int               fin, err, pops;
        logic             ty;
        logic [1:0]       nv;
        logic             fl;
        logic [23:0]      col;
        logic [7:0]       al;
        logic [59:0]      verts;      // {v0x,v0y,v1x,v1y,v2x,v2y}
    } vec_t;

    logic [31:0] fq[$];
    logic        force_empty = 1'b0;
    int          pops = 0;
    int          underflow = 0;
    int          nvec = 0;
    int          nmis = 0;
    vec_t        tv[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic update_fifo();
        fifo_empty = force_empty || (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
        #1;
    endtask

    // Advance one clock edge, applying the pop the DUT requested before it.
    task automatic tick();
        logic rd_pre, emp_pre;
        @(negedge clk);
        #4;
        rd_pre  = fifo_rd;
        emp_pre = fifo_empty;
        @(posedge clk);
        #1;
        if (rd_pre) begin
            pops++;
            if (emp_pre) underflow++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        update_fifo();
    endtask

    task automatic ack();
        if (decode_full) begin
            inst_ack = 1'b1;
            tick();
            inst_ack = 1'b0;
            tick();
        end
    endtask

    function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3, input int nw, sf, sl,
                                input int fin, err, np, input logic ty, input logic [1:0] nv,
                                input logic fl, input logic [23:0] col, input logic [7:0] al,
                                input logic [9:0] x0, y0, x1, y1, x2, y2);
        vec_t v;
        v.w = {w3, w2, w1, w0};
        v.nw = nw; v.sf = sf; v.sl = sl;
        v.fin = fin; v.err = err; v.pops = np;
        v.ty = ty; v.nv = nv; v.fl = fl; v.col = col; v.al = al;
        v.verts = {x0, y0, x1, y1, x2, y2};
        return v;
    endfunction

    function automatic logic [63:0] all_outs();
        return {decode_fin, decode_full, decode_err, fifo_rd, inst_type, num_vert, fill,
                color, alpha, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y} == '0 ? 64'd0 : 64'd1;
    endfunction

    initial begin
        int fin_first, fin_cnt, err_first, err_cnt, p0, uf0;

        // Expected fields accumulate: unused registers keep earlier values.
        tv[0] = mk(32'h1100_FF00, 32'h0005_0007, 32'h0064_00C8, 0, 3, 0, 0, 4, -1, 3,
                   1'b0, 2'd2, 1'b1, 24'h00FF00, 8'h00, 10'd5, 10'd7, 10'd100, 10'd200, 10'd0, 10'd0);
        tv[1] = mk(32'h2000_0ABC, 32'h0001_0002, 32'h0003_0004, 32'h03FF_0200, 4, 4, 2, 7, -1, 4,
                   1'b0, 2'd3, 1'b0, 24'h000ABC, 8'h00, 10'd1, 10'd2, 10'd3, 10'd4, 10'd1023, 10'd512);
        tv[2] = mk(32'h3000_0080, 0, 0, 0, 1, 0, 0, 2, -1, 1,
                   1'b1, 2'd0, 1'b0, 24'h000ABC, 8'h80, 10'd1, 10'd2, 10'd3, 10'd4, 10'd1023, 10'd512);
        tv[3] = mk(32'h7000_0000, 32'h3000_0045, 0, 0, 2, 0, 0, -1, 2, 1,
                   1'b1, 2'd0, 1'b0, 24'h000ABC, 8'h80, 10'd1, 10'd2, 10'd3, 10'd4, 10'd1023, 10'd512);
        tv[4] = mk(0, 0, 0, 0, 0, 0, 0, 2, -1, 1,
                   1'b1, 2'd0, 1'b0, 24'h000ABC, 8'h45, 10'd1, 10'd2, 10'd3, 10'd4, 10'd1023, 10'd512);
        tv[5] = mk(32'h1ABC_DEF1, 32'hFFFF_FFFF, 32'h0155_8AAA, 0, 3, 1, 1, 5, -1, 3,
                   1'b0, 2'd2, 1'b0, 24'hBCDEF1, 8'h45, 10'h3FF, 10'h3FF, 10'h155, 10'h2AA, 10'd1023, 10'd512);

        update_fifo();
        tick();
        tick();
        chk("reset.outputs_zero", all_outs(), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            ack();
            for (int k = 0; k < tv[i].nw; k++) fq.push_back(tv[i].w[k]);
            update_fifo();
            p0 = pops; uf0 = underflow;
            fin_first = -1; fin_cnt = 0; err_first = -1; err_cnt = 0;
            read_en = 1'b1;
            tick();                         // edge 0 samples read_en in IDLE
            read_en = 1'b0;
            for (int c = 1; c <= 12; c++) begin
                force_empty = (c >= tv[i].sf) && (c < tv[i].sf + tv[i].sl);
                update_fifo();
                if (decode_fin) begin fin_cnt++; if (fin_first < 0) fin_first = c; end
                if (decode_err) begin err_cnt++; if (err_first < 0) err_first = c; end
                tick();
            end
            force_empty = 1'b0;
            update_fifo();
            chk($sformatf("v%0d.fin_cycle", i), 64'(fin_first), 64'(tv[i].fin));
            chk($sformatf("v%0d.fin_count", i), 64'(fin_cnt), (tv[i].fin >= 0) ? 64'd1 : 64'd0);
            chk($sformatf("v%0d.err_cycle", i), 64'(err_first), 64'(tv[i].err));
            chk($sformatf("v%0d.err_count", i), 64'(err_cnt), (tv[i].err >= 0) ? 64'd1 : 64'd0);
            chk($sformatf("v%0d.pops", i), 64'(pops - p0), 64'(tv[i].pops));
            chk($sformatf("v%0d.no_underflow", i), 64'(underflow - uf0), 64'd0);
            chk($sformatf("v%0d.type_nv_fill", i), {inst_type, num_vert, fill}, {tv[i].ty, tv[i].nv, tv[i].fl});
            chk($sformatf("v%0d.color", i), 64'(color), 64'(tv[i].col));
            chk($sformatf("v%0d.alpha", i), 64'(alpha), 64'(tv[i].al));
            chk($sformatf("v%0d.vertices", i), 64'({v0_x, v0_y, v1_x, v1_y, v2_x, v2_y}), 64'(tv[i].verts));
            chk($sformatf("v%0d.full", i), 64'(decode_full), (tv[i].fin >= 0) ? 64'd1 : 64'd0);
        end
        chk("illegal.leftover_decoded", 64'(fq.size()), 64'd0);

        // Backpressure: LINE fields still unacknowledged, request held high.
        fq.push_back(32'h3000_0011);
        update_fifo();
        read_en = 1'b1;
        p0 = pops;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp.hold%0d.full_rd", c), {decode_full, fifo_rd}, 2'b10);
        end
        chk("bp.no_pops", 64'(pops - p0), 64'd0);
        inst_ack = 1'b1;
        tick();                             // cycle N: ack sampled
        inst_ack = 1'b0;
        chk("bp.n1.full_rd", {decode_full, fifo_rd}, 2'b00);
        tick();
        chk("bp.n2.hdr_pop", 64'(fifo_rd), 64'd1);
        read_en = 1'b0;
        tick();
        chk("bp.fin_alpha", {decode_fin, inst_type, alpha}, {1'b1, 1'b1, 8'h11});
        tick();
        chk("bp.full_after", 64'(decode_full), 64'd1);
        ack();

        // Reset after the first vertex pop of a TRI.
        fq.push_back(32'h2000_0123);
        fq.push_back(32'h0011_0022);
        fq.push_back(32'h0033_0044);
        fq.push_back(32'h0055_0066);
        update_fifo();
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        tick();
        tick();
        chk("rst.two_popped", 64'(fq.size()), 64'd2);
        rst = 1'b1;
        update_fifo();
        tick();
        rst = 1'b0;
        update_fifo();
        chk("rst.outputs_zero", all_outs(), 64'd0);
        chk("rst.no_pop_in_reset", 64'(fq.size()), 64'd2);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rst.idle%0d", c), {fifo_rd, decode_fin, 30'(fq.size())}, {1'b0, 1'b0, 30'd2});
        end
        chk("global.no_underflow", 64'(underflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/gpu_inst_decoder.md
# gpu_inst_decoder

Instruction decoder serving the GPU main controller. While the controller holds `read_en`, the decoder pops a 1–4-word instruction from the command FIFO and unpacks it into registered shape and alpha fields. It then returns `decode_fin`, `inst_type` and `decode_full` to the controller, and holds the fields until the consuming engine (line, fill or alpha) acknowledges them.

## Interface
Parameters:
- `CW`, 10, coordinate width (x and y).
- `DW`, 32, FIFO word width; fixed at 32 in this revision.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `read_en`  in  1  controller decode request (level).
- `fifo_empty`  in  1  command FIFO empty.
- `fifo_rdata`  in  32  FIFO head word; first-word-fall-through, valid when `fifo_empty`=0.
- `fifo_rd`  out  1  pop strobe; head advances at the same edge.
- `inst_ack`  in  1  consumer has latched the fields.
- `decode_fin`  out  1  one-cycle pulse: instruction fields are valid.
- `decode_full`  out  1  fields held and not yet acknowledged.
- `decode_err`  out  1  one-cycle pulse on an illegal opcode.
- `inst_type`  out  1  0 = shape, 1 = alpha.
- `num_vert`  out  2  2 = line, 3 = triangle, 0 = alpha.
- `fill`  out  1  fill request for the shape.
- `color`  out  24  RGB888.
- `alpha`  out  8  blend factor.
- `v0_x`, `v0_y`, `v1_x`, `v1_y`, `v2_x`, `v2_y`  out  `CW` each  vertex coordinates.

## Operation
Instruction word formats:
- Header word:
  - [31:28] opcode: 1 = LINE (2 vertex words follow), 2 = TRI (3 vertex words follow), 3 = ALPHA (no words follow). Any other opcode is illegal.
  - [24] fill flag (shapes only).
  - [23:0] color for shapes; [7:0] alpha value for ALPHA.
- Vertex word: x = [25:16], y = [9:0]. All other bits are ignored.

FSM states are IDLE, HDR, OPER and DONE.
- **IDLE**
  - Go to HDR when `read_en`=1 and `decode_full`=0.
  - While `decode_full`=1, `read_en` is ignored.
- **HDR**
  - If `fifo_empty`=1: stall, with `fifo_rd`=0.
  - Otherwise: `fifo_rd`=1 and the header is captured.
  - LINE or TRI:
    - Load `inst_type`=0, `num_vert`, `fill` and `color`.
    - Clear the vertex counter to 0.
    - Go to OPER.
  - ALPHA:
    - Load `inst_type`=1, `num_vert`=0, `alpha`; clear `fill`.
    - Go to DONE.
  - Illegal opcode:
    - Pop and discard the word.
    - Pulse `decode_err` on the next cycle.
    - Return to IDLE; field registers are unchanged.
- **OPER**
  - Each cycle with `fifo_empty`=0: `fifo_rd`=1, the word is written to vertex[count], and count increments.
  - When count = `num_vert`−1 is written, go to DONE.
  - Empty FIFO: stall with no pop.
- **DONE**
  - `decode_fin`=1 for exactly one cycle.
  - `decode_full` is set; return to IDLE.

Once HDR is entered, decoding runs to completion even if `read_en` drops.

Unused vertex registers:
- A LINE leaves `v2_x`/`v2_y` at their previous values.
- An ALPHA leaves all vertices unchanged.

`decode_full` next value = (state==DONE) | (`decode_full` & ~`inst_ack`).
- `inst_ack` while `decode_full`=0 is ignored, including during the DONE cycle.

`fifo_rd` is asserted only in HDR or OPER, and never while `fifo_empty`=1 (no underflow under any input).

## Timing
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including `fifo_rd`, `decode_fin`, `decode_full`, `decode_err` and all fields.
  - Vertex counter is 0.
- Reset mid-decode:
  - Aborts with no further pops.
  - Already-popped words are lost.
  - No `decode_fin` is produced.
- Latency with the FIFO non-empty, where cycle 0 is the edge that samples `read_en` in IDLE:
  - Header is popped in cycle 1.
  - Vertices are popped in cycles 2..1+N.
  - `decode_fin` is high in cycle 2+N. LINE = cycle 4, TRI = cycle 5, ALPHA = cycle 2.
- Each empty-FIFO cycle in HDR or OPER adds exactly one cycle.
- The earliest next decode is 1 cycle after `decode_full` clears: the `inst_ack` cycle clears it, IDLE samples `read_en` on the following edge.
- Fields change only on pop edges in HDR/OPER. They are stable from `decode_fin` until the next HDR pop.

## Test plan
- **LINE**
  - Stimulus: FIFO holds 0x1100_FF00, 0x0005_0007, 0x0064_00C8; `read_en` high.
  - Required: 3 consecutive `fifo_rd` pulses; `decode_fin` at cycle 4; `inst_type`=0, `num_vert`=2, `fill`=1, `color`=0x00FF00, v0=(5,7), v1=(100,200); `decode_full`=1.
- **TRI with stall**
  - Stimulus: header 0x2000_0ABC, then 3 vertex words, with `fifo_empty` forced high for 2 cycles after the second vertex.
  - Required: no `fifo_rd` during the stall; `decode_fin` at cycle 7; `num_vert`=3, v2 correct.
- **ALPHA**
  - Stimulus: header 0x3000_0080.
  - Required: `decode_fin` at cycle 2; `inst_type`=1, `alpha`=0x80, `num_vert`=0, vertices unchanged.
- **Illegal opcode**
  - Stimulus: header 0x7000_0000 followed by a valid ALPHA header.
  - Required: one pop, then a `decode_err` pulse with no `decode_fin`; the next `read_en` decodes the ALPHA normally.
- **Backpressure**
  - Stimulus: hold `read_en` high after a LINE decode with `inst_ack` low for 5 cycles.
  - Required: no pops and `decode_full` stays 1; `inst_ack` at cycle N → `decode_full`=0 at N+1 → HDR pop at N+2.
- **Reset mid-OPER**
  - Stimulus: assert `rst` after the first vertex pop of a TRI.
  - Required: next cycle all outputs are 0 and the state is IDLE; the remaining FIFO words are not popped until a new `read_en`.
